// File: rtl/pc_branch_sequencer_pkg.sv
// Shared definitions for the multicycle MIPS PC / branch sequencer.
//   state_t : branch sequencer FSM states
//   BR_*    : encodings of br_kind / PCWriteCondMux (condition mux select)
package mips_pc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [1:0] BR_NZ = 2'b00;  // bne: branch when result not zero
    localparam logic [1:0] BR_Z  = 2'b01;  // beq: branch when result zero
    localparam logic [1:0] BR_GT = 2'b10;  // bgt: branch when greater
    localparam logic [1:0] BR_OR = 2'b11;  // or-condition

endpackage

// File: rtl/pc_branch_sequencer_sat_counter.sv
// Saturating up-counter used for the debug branch statistics.
// Ports:
//   clk   : clock, all updates on rising edge
//   clear : synchronous clear to zero (takes priority over inc)
//   inc   : count up by one, holding at all-ones
//   count : current value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pc_branch_sequencer.sv
// Program counter owner and conditional-branch sequencer for the multicycle
// MIPS datapath. Performs unconditional PC writes (fetch PC+4, jumps) and
// steps conditional branches through SETUP/RESOLVE so the ALU flags and the
// condition mux have a full cycle to settle before the condition is sampled.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, br_kind      : branch request and condition select
//   branch_target       : branch target, captured with start
//   pc_inc, pc_seq      : unconditional write of the sequential PC
//   jump, jump_target   : unconditional write of the jump address
//   PCWriteFio          : condition mux result (bit 0 only)
//   PCWriteCondMux      : condition mux select
//   pc                  : program counter
//   busy, done, taken   : branch status (busy in SETUP/RESOLVE, done pulse)
//   protocol_err        : sticky illegal-request flag
//   branch_count        : resolved branches (saturating)
//   taken_count         : taken branches (saturating)
module pc_branch_sequencer
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       br_kind,
    input  logic [31:0]      branch_target,
    input  logic             pc_inc,
    input  logic [31:0]      pc_seq,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      PCWriteFio,
    output logic [1:0]       PCWriteCondMux,
    output logic [31:0]      pc,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             protocol_err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    state_t      state;
    logic [1:0]  sel_q;
    logic [31:0] tgt_q;

    // Only bit 0 of the condition mux result carries information.
    logic cond;
    logic unused_fio;
    assign cond       = PCWriteFio[0];
    assign unused_fio = ^PCWriteFio[31:1];

    logic any_req;
    assign any_req = start | jump | pc_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            PCWriteCondMux <= 2'b00;
            sel_q          <= 2'b00;
            tgt_q          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            taken          <= 1'b0;
            protocol_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sel_q          <= br_kind;
                        tgt_q          <= branch_target;
                        // Present the select already in SETUP so the mux
                        // output is stable for the whole of SETUP.
                        PCWriteCondMux <= br_kind;
                        busy           <= 1'b1;
                        state          <= SETUP;
                        // A jump or fetch colliding with start is dropped.
                        if (jump || pc_inc) begin
                            protocol_err <= 1'b1;
                        end
                    end else if (jump) begin
                        pc <= jump_target;
                    end else if (pc_inc) begin
                        pc <= pc_seq;
                    end
                end
                SETUP: begin
                    PCWriteCondMux <= sel_q;
                    state          <= RESOLVE;
                    if (any_req) begin
                        protocol_err <= 1'b1;
                    end
                end
                RESOLVE: begin
                    if (cond) begin
                        pc <= tgt_q;
                    end
                    taken <= cond;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                    if (any_req) begin
                        protocol_err <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (any_req) begin
                        protocol_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Statistics update on the resolving edge; reset clears them even if a
    // branch was mid-resolve.
    logic resolving;
    assign resolving = (state == RESOLVE);

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (resolving),
        .count (branch_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (resolving & cond),
        .count (taken_count)
    );

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Bench for pc_branch_sequencer: directed scenarios followed by random
// stimulus, compared every cycle against a transaction-timeline model.
module tb_pc_branch_sequencer;
    import mips_pc_pkg::*;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam int          CW  = 2;

    logic          clk = 1'b0;
    logic          reset, start, pc_inc, jump;
    logic [1:0]    br_kind;
    logic [31:0]   branch_target, pc_seq, jump_target, PCWriteFio;
    logic [1:0]    PCWriteCondMux;
    logic [31:0]   pc;
    logic          busy, done, taken, protocol_err;
    logic [CW-1:0] branch_count, taken_count;

    always #5 clk = ~clk;

    pc_branch_sequencer #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .br_kind(br_kind),
        .branch_target(branch_target), .pc_inc(pc_inc), .pc_seq(pc_seq),
        .jump(jump), .jump_target(jump_target), .PCWriteFio(PCWriteFio),
        .PCWriteCondMux(PCWriteCondMux), .pc(pc), .busy(busy), .done(done),
        .taken(taken), .protocol_err(protocol_err),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a branch accepted in cycle b occupies cycles b+1..b+3;
    // the condition is sampled at the end of cycle b+2 and done shows in b+3.
    int          cyc = 0;
    int          bstart = 0;
    bit          active = 0;
    logic [31:0] m_pc = RPC, m_tgt = '0;
    logic [1:0]  m_mux = 2'b00;
    bit          m_taken = 0, m_err = 0;
    int          m_bc = 0, m_tc = 0;
    int          cmax = (1 << CW) - 1;

    function automatic bit m_busy(input int c);
        return active && (c - bstart >= 1) && (c - bstart <= 2);
    endfunction

    function automatic bit m_done(input int c);
        return active && (c - bstart == 3);
    endfunction

    task automatic model_edge(input bit r, input bit s, input logic [1:0] k,
                              input logic [31:0] t, input bit i, input logic [31:0] q,
                              input bit j, input logic [31:0] jt, input logic [31:0] f);
        int age;
        age = cyc - bstart;
        if (r) begin
            m_pc = RPC; active = 0; m_mux = 2'b00; m_taken = 0; m_err = 0;
            m_bc = 0; m_tc = 0;
        end else if (active && age >= 1 && age <= 3) begin
            if (s || i || j) m_err = 1;
            if (age == 2) begin
                if (f[0]) m_pc = m_tgt;
                m_taken = f[0];
                if (m_bc < cmax) m_bc++;
                if (f[0] && m_tc < cmax) m_tc++;
            end
        end else begin
            active = 0;
            if (s) begin
                active = 1; bstart = cyc; m_tgt = t; m_mux = k;
                if (i || j) m_err = 1;
            end else if (j) begin
                m_pc = jt;
            end else if (i) begin
                m_pc = q;
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        chk("pc", pc, m_pc);
        chk("busy", 32'(busy), 32'(m_busy(cyc)));
        chk("done", 32'(done), 32'(m_done(cyc)));
        chk("taken", 32'(taken), 32'(m_taken));
        chk("protocol_err", 32'(protocol_err), 32'(m_err));
        chk("branch_count", 32'(branch_count), 32'(m_bc));
        chk("taken_count", 32'(taken_count), 32'(m_tc));
        chk("cond_mux", 32'(PCWriteCondMux), 32'(m_mux));
    endtask

    task automatic step(input bit r, input bit s, input logic [1:0] k,
                        input logic [31:0] t, input bit i, input logic [31:0] q,
                        input bit j, input logic [31:0] jt, input logic [31:0] f);
        @(negedge clk);
        reset = r; start = s; br_kind = k; branch_target = t; pc_inc = i;
        pc_seq = q; jump = j; jump_target = jt; PCWriteFio = f;
        @(posedge clk);
        model_edge(r, s, k, t, i, q, j, jt, f);
        #1;
        compare_all();
    endtask

    task automatic idle(input logic [31:0] f);
        step(0, 0, 2'b00, 32'h0, 0, 32'h0, 0, 32'h0, f);
    endtask

    task automatic do_reset();
        step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; start = 0; br_kind = 0; branch_target = 0; pc_inc = 0;
        pc_seq = 0; jump = 0; jump_target = 0; PCWriteFio = 0;

        // Reset then idle
        do_reset();
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bc", 32'(branch_count), 0);
        chk("rst_mux", 32'(PCWriteCondMux), 0);

        // Taken beq
        step(0, 0, 0, 0, 0, 0, 1, 32'h100, 0);
        chk("jump_pc", pc, 32'h100);
        step(0, 1, BR_Z, 32'h200, 0, 0, 0, 0, 0);
        chk("beq_setup_mux", 32'(PCWriteCondMux), 32'(BR_Z));
        chk("beq_setup_busy", 32'(busy), 1);
        idle(0);
        chk("beq_resolve_mux", 32'(PCWriteCondMux), 32'(BR_Z));
        chk("beq_resolve_pc", pc, 32'h100);
        idle(32'h1);
        chk("beq_pc", pc, 32'h200);
        chk("beq_done", 32'(done), 1);
        chk("beq_taken", 32'(taken), 1);
        chk("beq_bc", 32'(branch_count), 1);
        chk("beq_tc", 32'(taken_count), 1);
        idle(0);
        chk("beq_done_once", 32'(done), 0);

        // Not-taken bne
        step(0, 1, BR_NZ, 32'h300, 0, 0, 0, 0, 0);
        idle(0);
        idle(32'hFFFF_FFFE);
        chk("bne_pc", pc, 32'h200);
        chk("bne_taken", 32'(taken), 0);
        chk("bne_bc", 32'(branch_count), 2);
        chk("bne_tc", 32'(taken_count), 1);
        idle(0);

        // pc_inc during SETUP is illegal and dropped
        step(0, 1, BR_GT, 32'h400, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h104, 0, 0, 0);
        idle(0);
        chk("ovl_pc", pc, 32'h200);
        chk("ovl_err", 32'(protocol_err), 1);
        idle(0); idle(0); idle(0);
        chk("ovl_err_sticky", 32'(protocol_err), 1);

        // start with jump in IDLE: branch wins, error flagged
        do_reset();
        step(0, 1, BR_OR, 32'h500, 0, 0, 1, 32'h800, 0);
        chk("sj_err", 32'(protocol_err), 1);
        idle(0);
        idle(32'h1);
        chk("sj_pc", pc, 32'h500);
        idle(0);

        // jump with pc_inc: jump wins, no error
        do_reset();
        step(0, 0, 0, 0, 1, 32'h104, 1, 32'h800, 0);
        chk("ji_pc", pc, 32'h800);
        chk("ji_err", 32'(protocol_err), 0);

        // Reset during RESOLVE aborts the branch
        step(0, 1, BR_Z, 32'h900, 0, 0, 0, 0, 0);
        idle(0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h1);
        chk("abort_pc", pc, RPC);
        chk("abort_done", 32'(done), 0);
        idle(0);
        chk("abort_done2", 32'(done), 0);

        // Five taken branches saturate both 2-bit counters
        for (int b = 0; b < 5; b++) begin
            step(0, 1, BR_Z, 32'h1000 + 32'(b) * 4, 0, 0, 0, 0, 0);
            idle(0);
            idle(32'h1);
            idle(0);
        end
        chk("sat_bc", 32'(branch_count), 3);
        chk("sat_tc", 32'(taken_count), 3);

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < 25,
                 2'($urandom),
                 $urandom,
                 $urandom_range(0, 99) < 30,
                 $urandom,
                 $urandom_range(0, 99) < 15,
                 $urandom,
                 $urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_branch_sequencer.md
Name: pc_branch_sequencer

Overview:
- Sequences conditional branches in the multicycle MIPS datapath and owns the program counter register.
- Sits directly upstream of the branch-condition select mux: drives its 2-bit select (PCWriteCondMux) and consumes its result (PCWriteFio) to decide whether the PC takes the branch target.
- Also performs unconditional PC writes (PC+4 at fetch, jumps).
- Keeps saturating branch/taken counters for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of branch_count and taken_count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to resolve a branch (from main control, decode state).
- br_kind  input  2  condition select: 00 not-zero (bne), 01 zero (beq), 10 greater (bgt), 11 or-condition.
- branch_target  input  32  target address, sampled on the start cycle.
- pc_inc  input  1  unconditional write of pc_seq (fetch).
- pc_seq  input  32  sequential next PC (PC+4 from ALU).
- jump  input  1  unconditional write of jump_target.
- jump_target  input  32  jump address.
- PCWriteFio  input  32  condition from the select mux; only bit 0 is used, bits 31:1 ignored.
- PCWriteCondMux  output  2  select driven to the condition mux.
- pc  output  32  current program counter.
- busy  output  1  high while a branch is in progress (states SETUP, RESOLVE).
- done  output  1  one-cycle pulse when the branch has resolved.
- taken  output  1  result of the last resolved branch; held until the next resolve.
- protocol_err  output  1  sticky flag for illegal requests; cleared only by reset.
- branch_count  output  CNT_W  resolved branches, saturating.
- taken_count  output  CNT_W  taken branches, saturating.

Behaviour:
- Reset values:
  - pc = RESET_PC; state = IDLE; PCWriteCondMux = 2'b00.
  - busy = 0, done = 0, taken = 0, protocol_err = 0, both counters = 0.
  - Reset mid-branch aborts the branch with no PC write.
- FSM states: IDLE, SETUP, RESOLVE, DONE.
- IDLE:
  - start = 1: latch br_kind into sel_q and branch_target into tgt_q, then go to SETUP.
  - Otherwise, jump = 1: pc <= jump_target.
  - Otherwise, pc_inc = 1: pc <= pc_seq.
  - Priority in IDLE: start > jump > pc_inc. If start arrives with jump or pc_inc, the loser is dropped and protocol_err is set. jump with pc_inc writes jump_target with no error.
- SETUP:
  - PCWriteCondMux = sel_q, giving one full cycle for ALU flags and the mux to settle.
  - Go to RESOLVE.
- RESOLVE:
  - PCWriteCondMux stays sel_q.
  - Sample c = PCWriteFio[0]. If c = 1, pc <= tgt_q.
  - taken <= c; branch_count += 1 (saturating); taken_count += c (saturating).
  - Go to DONE.
- DONE:
  - done = 1 for exactly this cycle.
  - Go to IDLE.
- Latency: start at cycle N → pc updated at the edge ending cycle N+2 (visible in N+3) → done high in cycle N+3. A new start is accepted from cycle N+4.
- busy is 1 exactly in SETUP and RESOLVE.
- start, jump or pc_inc in SETUP, RESOLVE or DONE: ignored, protocol_err set, pc not changed.
- PCWriteCondMux outside SETUP/RESOLVE holds its last value; it is don't-care for the mux.
- Counters saturate at all-ones and do not wrap.
- No arithmetic on pc; addresses pass through unchanged. Alignment is not checked.

Decomposition:
- Shared package mips_pc_pkg holds:
  - state enum IDLE/SETUP/RESOLVE/DONE;
  - br_kind constants BR_NZ = 2'b00, BR_Z = 2'b01, BR_GT = 2'b10, BR_OR = 2'b11.
- One natural sub-module: sat_counter (parameter CNT_W, inputs inc/clear, saturating output), instantiated twice.
- The FSM and PC register stay in the top module.

Test Plan:
- Reset then idle: hold reset 2 cycles with RESET_PC = 32'h0040_0000 → pc = 32'h0040_0000, busy = 0, done = 0, counters = 0, PCWriteCondMux = 00.
- Taken beq: pc = 32'h100, start with br_kind = 01 and branch_target = 32'h200; PCWriteFio = 1 during RESOLVE → PCWriteCondMux = 01 in SETUP and RESOLVE; pc = 32'h200 at cycle N+3; done pulses once at N+3; taken = 1; branch_count = 1; taken_count = 1.
- Not-taken bne: br_kind = 00, PCWriteFio = 32'hFFFF_FFFE (bit 0 = 0) → pc unchanged, taken = 0, branch_count increments, taken_count unchanged.
- Illegal overlap: assert pc_inc = 1 (pc_seq = 32'h104) during SETUP → pc not written, protocol_err = 1 and stays 1 until reset.
- Simultaneous requests in IDLE:
  - start with jump (jump_target = 32'h800) → branch is taken, pc is not set to 32'h800, protocol_err = 1.
  - jump with pc_inc → pc = 32'h800, no error.
- Reset mid-branch and saturation:
  - Reset during RESOLVE with PCWriteFio = 1 → pc = RESET_PC, no done pulse.
  - With CNT_W = 2, resolve 5 taken branches → both counters read 3.
